hazard_sched: RTL and testbench

//  Pipeline hazard scheduler for the 5-stage core (IF/ID/EX/MEM/WB). Tracks destination registers of
//  in-flight instrs and generates the EX-stage forwarding selects (forwardA/forwardB), the load-use

---
 rtl/hazard_sched_if.sv | 40 ++++
 rtl/hazard_sched.sv | 194 +++++++++++++++++++
 tb/tb_hazard_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_sched_if.sv
// hazard_sched_if: bundles the ID-stage instruction fields, the EX branch
// resolution and the scheduler's control outputs between the core and
// hazard_sched. The core drives through the master modport; the scheduler
// uses the slave modport.
interface hazard_sched_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_src0;
  logic [REG_W-1:0] id_src1;
  logic             id_use0;
  logic             id_use1;
  logic [REG_W-1:0] id_dst;
  logic             id_we;
  logic             id_is_load;
  logic             id_hlt;
  logic             br_ctrl;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             stall;
  logic             flush;
  logic             prev_br_ctrl;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_src0, id_src1, id_use0, id_use1, id_dst, id_we, id_is_load,
           id_hlt, br_ctrl,
    input  forwardA, forwardB, stall, flush, prev_br_ctrl, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src0, id_src1, id_use0, id_use1, id_dst, id_we, id_is_load,
           id_hlt, br_ctrl,
    output forwardA, forwardB, stall, flush, prev_br_ctrl, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// hazard_sched: hazard scheduler for the 5-stage IF/ID/EX/MEM/WB core.
// Tracks the destinations of the instructions in EX, MEM and WB, produces the
// registered EX forwarding selects, the combinational load-use stall and
// branch flush, the delayed branch flag and the sticky halt.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero and no counter flops exist.
module hazard_sched #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_sched_if.slave bus
);

  // EX-stage entry: every field is needed (the load flag drives load-use).
  logic             ex_vld_r;
  logic             ex_we_r;
  logic             ex_ld_r;
  logic             ex_hlt_r;
  logic [REG_W-1:0] ex_dst_r;
  // MEM-stage entry: a load here is already forwardable, so no load flag.
  logic             mem_vld_r;
  logic             mem_we_r;
  logic             mem_hlt_r;
  logic [REG_W-1:0] mem_dst_r;
  // WB-stage entry: only the halt detection looks at it.
  logic             wb_vld_r;
  logic             wb_hlt_r;

  logic [1:0] fwd_a_r;
  logic [1:0] fwd_b_r;
  logic       prev_br_r;
  logic       halted_r;

  logic       hit_ex0_s;
  logic       hit_ex1_s;
  logic       hit_mem0_s;
  logic       hit_mem1_s;
  logic       load_use_s;
  logic       stall_s;
  logic       flush_s;
  logic       issue_s;
  logic [1:0] fwd_a_nxt_s;
  logic [1:0] fwd_b_nxt_s;

  // A producer is a hazard only if it is real, writes, targets a non-zero
  // register and that register is actually read by the ID instruction.
  function automatic logic src_hit(input logic vld, input logic we,
                                   input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src,
                                   input logic use_src);
    return vld & we & (dst != {REG_W{1'b0}}) & (dst == src) & use_src;
  endfunction

  assign hit_ex0_s  = src_hit(ex_vld_r,  ex_we_r,  ex_dst_r,  bus.id_src0, bus.id_use0);
  assign hit_ex1_s  = src_hit(ex_vld_r,  ex_we_r,  ex_dst_r,  bus.id_src1, bus.id_use1);
  assign hit_mem0_s = src_hit(mem_vld_r, mem_we_r, mem_dst_r, bus.id_src0, bus.id_use0);
  assign hit_mem1_s = src_hit(mem_vld_r, mem_we_r, mem_dst_r, bus.id_src1, bus.id_use1);
  assign load_use_s = ex_ld_r & (hit_ex0_s | hit_ex1_s);

  // Stall/flush arbitration: halt dominates, then a taken branch squashes the
  // would-be stalled instruction, otherwise stall on a load-use hazard.
  always_comb begin
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (halted_r) begin
      stall_s = 1'b1;
      flush_s = 1'b0;
    end else if (bus.br_ctrl) begin
      stall_s = 1'b0;
      flush_s = 1'b1;
    end else begin
      stall_s = load_use_s;
      flush_s = 1'b0;
    end
  end

  // The ID instruction enters EX only when nothing holds or squashes it.
  assign issue_s = ~(stall_s | flush_s | halted_r);

  // Forward-select priority: the EX-resident (newest) producer wins; its
  // result will be in MEM when the consumer reaches EX.
  always_comb begin
    fwd_a_nxt_s = 2'b00;
    fwd_b_nxt_s = 2'b00;
    if (hit_ex0_s) begin
      fwd_a_nxt_s = 2'b10;
    end else if (hit_mem0_s) begin
      fwd_a_nxt_s = 2'b01;
    end else begin
      fwd_a_nxt_s = 2'b00;
    end
    if (hit_ex1_s) begin
      fwd_b_nxt_s = 2'b10;
    end else if (hit_mem1_s) begin
      fwd_b_nxt_s = 2'b01;
    end else begin
      fwd_b_nxt_s = 2'b00;
    end
  end

  // Tracker shift EX->MEM->WB; frozen once the core has halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_r  <= 1'b0;
      ex_we_r   <= 1'b0;
      ex_ld_r   <= 1'b0;
      ex_hlt_r  <= 1'b0;
      ex_dst_r  <= {REG_W{1'b0}};
      mem_vld_r <= 1'b0;
      mem_we_r  <= 1'b0;
      mem_hlt_r <= 1'b0;
      mem_dst_r <= {REG_W{1'b0}};
      wb_vld_r  <= 1'b0;
      wb_hlt_r  <= 1'b0;
    end else if (!halted_r) begin
      ex_vld_r  <= issue_s;
      ex_we_r   <= issue_s & bus.id_we;
      ex_ld_r   <= issue_s & bus.id_is_load;
      ex_hlt_r  <= issue_s & bus.id_hlt;
      ex_dst_r  <= issue_s ? bus.id_dst : {REG_W{1'b0}};
      mem_vld_r <= ex_vld_r;
      mem_we_r  <= ex_we_r;
      mem_hlt_r <= ex_hlt_r;
      mem_dst_r <= ex_dst_r;
      wb_vld_r  <= mem_vld_r;
      wb_hlt_r  <= mem_hlt_r;
    end
  end

  // Forward selects registered for the EX cycle; a bubble gets 2'b00 and the
  // selects hold while halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else if (halted_r) begin
      fwd_a_r <= fwd_a_r;
      fwd_b_r <= fwd_b_r;
    end else if (stall_s || flush_s) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else begin
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
    end
  end

  // Delayed branch flag and sticky halt once HLT has reached WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_br_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      prev_br_r <= bus.br_ctrl;
      halted_r  <= halted_r | (wb_vld_r & wb_hlt_r);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating counts of load-use stall cycles and taken-branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && !halted_r && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

  assign bus.forwardA     = fwd_a_r;
  assign bus.forwardB     = fwd_b_r;
  assign bus.stall        = stall_s;
  assign bus.flush        = flush_s;
  assign bus.prev_br_ctrl = prev_br_r;
  assign bus.halted       = halted_r;

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed scoreboard bench for hazard_sched. Each step
// drives one ID instruction (plus br_ctrl) and pushes the expected
// combinational stall/flush and the expected registered outputs after the
// following clock edge; both are popped and compared when produced.
module tb_hazard_sched;

  localparam int REG_W = 4;
  localparam int CNT_W = 16;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;

  hazard_sched_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_sched #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    logic  st;
    logic  fl;
  } comb_t;

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       pb;
    logic       hl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int scnt_m  = 0;
  int fcnt_m  = 0;
  logic hl_now = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_src0 = 4'd0; bus.id_use0 = 1'b0;
    bus.id_src1 = 4'd0; bus.id_use1 = 1'b0;
    bus.id_dst = 4'd0; bus.id_we = 1'b0; bus.id_is_load = 1'b0;
    bus.id_hlt = 1'b0; bus.br_ctrl = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fa"}, 32'(bus.forwardA), 32'd0);
    check({tag, "_fb"}, 32'(bus.forwardB), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check({tag, "_flush"}, 32'(bus.flush), 32'd0);
    check({tag, "_pb"}, 32'(bus.prev_br_ctrl), 32'd0);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
    check({tag, "_scnt"}, 32'(bus.stall_cnt), 32'd0);
    check({tag, "_fcnt"}, 32'(bus.flush_cnt), 32'd0);
  endtask

  // One ID cycle: drive, check stall/flush, clock, check registered outputs.
  task automatic cyc(input string tag,
                     input logic [3:0] s0, input logic u0,
                     input logic [3:0] s1, input logic u1,
                     input logic [3:0] d, input logic we, input logic ld,
                     input logic hlt, input logic br,
                     input logic e_st, input logic e_fl,
                     input logic [1:0] e_fa, input logic [1:0] e_fb,
                     input logic e_pb, input logic e_hl);
    comb_t c;
    reg_t  r;
    @(negedge clk);
    bus.id_src0 = s0; bus.id_use0 = u0;
    bus.id_src1 = s1; bus.id_use1 = u1;
    bus.id_dst = d; bus.id_we = we; bus.id_is_load = ld;
    bus.id_hlt = hlt; bus.br_ctrl = br;
    comb_q.push_back('{tag: tag, st: e_st, fl: e_fl});
    if (e_st && !hl_now) scnt_m++;
    if (e_fl) fcnt_m++;
    reg_q.push_back('{tag: tag, fa: e_fa, fb: e_fb, pb: e_pb, hl: e_hl,
                      sc: PERF ? CNT_W'(scnt_m) : {CNT_W{1'b0}},
                      fc: PERF ? CNT_W'(fcnt_m) : {CNT_W{1'b0}}});
    #2;
    if (comb_q.size() == 0) begin
      check({tag, "_comb_q_empty"}, 32'd1, 32'd0);
    end else begin
      c = comb_q.pop_front();
      check({c.tag, "_stall"}, 32'(bus.stall), 32'(c.st));
      check({c.tag, "_flush"}, 32'(bus.flush), 32'(c.fl));
    end
    @(posedge clk);
    #1;
    if (reg_q.size() == 0) begin
      check({tag, "_reg_q_empty"}, 32'd1, 32'd0);
    end else begin
      r = reg_q.pop_front();
      check({r.tag, "_fa"}, 32'(bus.forwardA), 32'(r.fa));
      check({r.tag, "_fb"}, 32'(bus.forwardB), 32'(r.fb));
      check({r.tag, "_pb"}, 32'(bus.prev_br_ctrl), 32'(r.pb));
      check({r.tag, "_halted"}, 32'(bus.halted), 32'(r.hl));
      check({r.tag, "_scnt"}, 32'(bus.stall_cnt), 32'(r.sc));
      check({r.tag, "_fcnt"}, 32'(bus.flush_cnt), 32'(r.fc));
      hl_now = r.hl;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //   tag       s0   u0   s1   u1   dst  we   ld   hlt  br   st   fl   fa     fb     pb   hl
    // 1: back-to-back ALU dependency -> MEM forward on src0
    cyc("add_r1",  4'd2,1'b1,4'd3,1'b1,4'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("dep_ex",  4'd1,1'b1,4'd3,1'b1,4'd2,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,1'b0);
    cyc("nop_c",   4'd0,1'b0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    // 2: producer two ahead -> WB forward on src1
    cyc("add_r1b", 4'd6,1'b1,4'd7,1'b1,4'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("nop_e",   4'd0,1'b0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("sub_wb",  4'd5,1'b1,4'd1,1'b1,4'd4,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b0,1'b0);
    // 3: load-use -> one bubble then WB forward on both sources
    cyc("lw_r1",   4'd2,1'b1,4'd0,1'b0,4'd1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("lu_stall",4'd1,1'b1,4'd1,1'b1,4'd2,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("lu_go",   4'd1,1'b1,4'd1,1'b1,4'd2,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b0,1'b0);
    // 4: R0 is never a hazard, ALU or load producer
    cyc("add_r0",  4'd3,1'b1,4'd3,1'b1,4'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("rd_r0",   4'd0,1'b1,4'd0,1'b1,4'd5,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("lw_r0",   4'd0,1'b0,4'd0,1'b0,4'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("rd_r0_ld",4'd0,1'b1,4'd0,1'b1,4'd6,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    // 5: taken branch over a load-use -> flush wins, bubble enters EX
    cyc("lw_r1b",  4'd3,1'b1,4'd0,1'b0,4'd1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("br_flush",4'd1,1'b1,4'd3,1'b1,4'd2,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,1'b1,1'b0);
    cyc("post_br", 4'd1,1'b1,4'd1,1'b1,4'd7,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b0,1'b0);
    // newest producer wins over older one to the same register
    cyc("add_r3a", 4'd0,1'b0,4'd0,1'b0,4'd3,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("add_r3b", 4'd0,1'b0,4'd0,1'b0,4'd3,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("newest",  4'd3,1'b1,4'd3,1'b1,4'd8,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,1'b0,1'b0);

    // 6: reset pulse, then HLT on the third cycle after release
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_pulse");
    scnt_m = 0; fcnt_m = 0; hl_now = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("h_nop1",  4'd0,1'b0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("h_nop2",  4'd0,1'b0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("hlt",     4'd0,1'b0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("h_add_r4",4'd0,1'b0,4'd0,1'b0,4'd4,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);
    cyc("h_add_r5",4'd4,1'b1,4'd0,1'b0,4'd5,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,1'b0);
    cyc("h_in_wb", 4'd4,1'b1,4'd5,1'b1,4'd6,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,1'b0,1'b1);
    cyc("halted",  4'd0,1'b0,4'd0,1'b0,4'd0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b01,2'b10,1'b1,1'b1);

    // reset asserted while the halt stall is held
    @(negedge clk);
    idle();
    #1;
    check("mid_stall_pre", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_stall");
    scnt_m = 0; fcnt_m = 0; hl_now = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("first",   4'd1,1'b1,4'd1,1'b1,4'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0);

    check("sb_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
